// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the memory stage and its request timer.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_req_timer.sv
// Clear/enable cycle counter that flags the last permitted wait cycle of a bus request.
module mem_req_timer
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Counter next-state; the owner clears it before it can pass LAST.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i & (count_q == LAST);

endmodule

// File: rtl/mem_access.sv
// Pipeline memory stage: issues req/ack data-memory transactions, stalls upstream
// while one is outstanding, and hands a registered result to writeback.
module mem_access
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] exeOut,
  input  logic [DATA_W-1:0] RegData1_o,
  input  logic              valid_in,
  input  logic              memRead,
  input  logic              memWrite,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] memOut,
  output logic              valid_out,
  output logic              misalign_err,
  output logic              bus_err
);

  mem_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_out_q, mem_out_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic mem_op_s;
  logic aligned_s;
  logic in_req_s;
  logic expire_s;

  assign mem_op_s  = memRead | memWrite;
  assign aligned_s = ((exeOut[1:0] & WORD_ALIGN_MASK) == 2'b00);
  assign in_req_s  = (state_q == REQ);

  mem_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (~in_req_s),
    .enable_i (in_req_s),
    .expire_o (expire_s)
  );

  // Stall in the issuing cycle too, so upstream holds the op until DONE releases it.
  assign stall = in_req_s | ((state_q == IDLE) & valid_in & mem_op_s & aligned_s);

  // Next-state and output decode; result pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_out_d  = mem_out_q;
    valid_d    = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && mem_op_s && aligned_s) begin
          addr_d  = exeOut;
          wdata_d = RegData1_o;
          we_d    = memWrite;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (valid_in && mem_op_s) begin
          misalign_d = 1'b1;
          valid_d    = 1'b1;
          mem_out_d  = {DATA_W{1'b0}};
        end else if (valid_in) begin
          valid_d   = 1'b1;
          mem_out_d = exeOut;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack in the expiry cycle still completes normally.
        if (dmem_ack) begin
          req_d     = 1'b0;
          valid_d   = 1'b1;
          mem_out_d = we_q ? addr_q : dmem_rdata;
          state_d   = DONE;
        end else if (expire_s) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          valid_d   = 1'b1;
          mem_out_d = {DATA_W{1'b0}};
          state_d   = DONE;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {DATA_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      mem_out_q  <= {DATA_W{1'b0}};
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_out_q  <= mem_out_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign memOut       = mem_out_q;
  assign valid_out    = valid_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, load, store, misalignment, timeout and reset.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic [31:0] exeOut;
  logic [31:0] RegData1_o;
  logic        valid_in;
  logic        memRead;
  logic        memWrite;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] memOut;
  logic        valid_out;
  logic        misalign_err;
  logic        bus_err;

  int vectors;
  int miscompares;

  mem_access #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .exeOut       (exeOut),
    .RegData1_o   (RegData1_o),
    .valid_in     (valid_in),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .memOut       (memOut),
    .valid_out    (valid_out),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic v, input logic [31:0] d,
                            input logic mis, input logic be, input logic req);
    chk1({tag, "_valid"}, valid_out, v);
    chk32({tag, "_memOut"}, memOut, d);
    chk1({tag, "_misalign"}, misalign_err, mis);
    chk1({tag, "_bus_err"}, bus_err, be);
    chk1({tag, "_req"}, dmem_req, req);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish expected finish by 20000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    exeOut      = 32'h0;
    RegData1_o  = 32'h0;
    valid_in    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    dmem_ack    = 1'b0;
    dmem_rdata  = 32'h0;
    step();
    step();
    chk_result("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk1("reset_we", dmem_we, 1'b0);
    chk32("reset_addr", dmem_addr, 32'h0);
    chk32("reset_wdata", dmem_wdata, 32'h0);
    chk1("reset_stall", stall, 1'b0);
    rst = 1'b0;
    step();

    // Pass-through
    exeOut   = 32'h0000_1234;
    valid_in = 1'b1;
    #1;
    chk1("pass_stall0", stall, 1'b0);
    step();
    chk_result("pass", 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    chk1("pass_stall1", stall, 1'b0);
    valid_in = 1'b0;
    step();
    chk1("pass_pulse", valid_out, 1'b0);

    // Load with ack in the third request cycle
    memRead = 1'b1;
    exeOut  = 32'h0000_0100;
    valid_in = 1'b1;
    #1;
    chk1("ld_stall_issue", stall, 1'b1);
    step();
    chk1("ld_req1", dmem_req, 1'b1);
    chk32("ld_addr", dmem_addr, 32'h0000_0100);
    chk1("ld_we", dmem_we, 1'b0);
    chk1("ld_stall1", stall, 1'b1);
    chk1("ld_valid_busy", valid_out, 1'b0);
    step();
    chk1("ld_req2", dmem_req, 1'b1);
    step();
    chk1("ld_req3", dmem_req, 1'b1);
    chk1("ld_stall3", stall, 1'b1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0;
    chk_result("ld_done", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk1("ld_stall_done", stall, 1'b0);
    valid_in = 1'b0;
    memRead  = 1'b0;
    step();
    chk1("ld_pulse", valid_out, 1'b0);

    // Store
    memWrite   = 1'b1;
    exeOut     = 32'h0000_0200;
    RegData1_o = 32'h0000_CAFE;
    valid_in   = 1'b1;
    step();
    chk1("st_req1", dmem_req, 1'b1);
    chk1("st_we", dmem_we, 1'b1);
    chk32("st_wdata1", dmem_wdata, 32'h0000_CAFE);
    chk32("st_addr", dmem_addr, 32'h0000_0200);
    RegData1_o = 32'h1111_1111;
    exeOut     = 32'h0000_0300;
    step();
    chk32("st_wdata_hold", dmem_wdata, 32'h0000_CAFE);
    chk32("st_addr_hold", dmem_addr, 32'h0000_0200);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    step();
    dmem_ack = 1'b0;
    chk_result("st_done", 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    valid_in = 1'b0;
    memWrite = 1'b0;
    step();

    // Read and write together behave as a store
    memRead  = 1'b1;
    memWrite = 1'b1;
    exeOut   = 32'h0000_0400;
    valid_in = 1'b1;
    step();
    chk1("rw_we", dmem_we, 1'b1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk_result("rw_done", 1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0);
    valid_in = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    step();

    // Misaligned load
    memRead  = 1'b1;
    exeOut   = 32'h0000_0102;
    valid_in = 1'b1;
    #1;
    chk1("mis_stall", stall, 1'b0);
    step();
    chk_result("mis", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    valid_in = 1'b0;
    memRead  = 1'b0;
    step();
    chk_result("mis_pulse", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Timeout with no ack
    memRead  = 1'b1;
    exeOut   = 32'h0000_0104;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    memRead  = 1'b0;
    repeat (15) step();
    chk1("to_req16", dmem_req, 1'b1);
    chk1("to_stall16", stall, 1'b1);
    chk1("to_bus_err16", bus_err, 1'b0);
    step();
    chk_result("to_done", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    chk1("to_pulse", bus_err, 1'b0);

    // Ack in the expiry cycle wins
    memRead  = 1'b1;
    exeOut   = 32'h0000_0108;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    memRead  = 1'b0;
    repeat (15) step();
    chk1("toack_req16", dmem_req, 1'b1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 1'b0;
    chk_result("toack_done", 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    step();

    // Reset two cycles into a request
    memRead  = 1'b1;
    exeOut   = 32'h0000_010C;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    memRead  = 1'b0;
    step();
    chk1("rst_req_before", dmem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_result("rst_async", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk32("rst_async_addr", dmem_addr, 32'h0);
    chk1("rst_async_stall", stall, 1'b0);
    step();
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    step();
    dmem_ack = 1'b0;
    chk_result("late_ack", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk1("late_ack2_valid", valid_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
